avaliador_polinomio: RTL and testbench
======================================

Name: avaliador_polinomio

Overview:
Parametrised polynomial evaluator combining a Horner-method datapath and its own control FSM in one block. It is the successor of the fixed 16-bit A/B/C/X operational block. It adds configurable word width, configurable maximum degree, a loadable coefficient bank, runtime degree selection, a start/done handshake and an overflow flag. It computes P(x) = c[g]·x^g + … + c[1]·x + c[0], unsigned, modulo 2^WIDTH.

Parameters:
WIDTH, 16, data width of coefficients, x and result
DEGREE, 3, maximum polynomial degree; the coefficient bank holds DEGREE+1 words
AW, 2, coefficient address / degree field width; must satisfy 2^AW >= DEGREE+1

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
coef_we  input  1  coefficient write enable
coef_addr  input  AW  coefficient index (0 = constant term)
coef_data  input  WIDTH  coefficient write data
grau  input  AW  degree for this evaluation, sampled with start
x  input  WIDTH  evaluation point, sampled with start
start  input  1  start request, level-sampled in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when resultado is valid
resultado  output  WIDTH  last evaluation result, held until the next completion
overflow  output  1  high if the last evaluation wrapped

Behaviour:
- Reset is asynchronous and active-high. On reset: all coefficients = 0, acc = 0, resultado = 0, done = 0, overflow = 0, state = IDLE. Reset asserted mid-operation aborts the evaluation with no done pulse.
- Coefficient write: at a clock edge with coef_we=1, state IDLE and coef_addr <= DEGREE, c[coef_addr] <= coef_data. The write is ignored when busy=1 or coef_addr > DEGREE.
- FSM states: IDLE, MUL, ADD, FIN.
- IDLE, on an edge with start=1:
  - g <= min(grau, DEGREE); x_reg <= x; acc <= c[g]; idx <= g; overflow <= 0.
  - Next state is MUL if g > 0, otherwise FIN. For g = 0, resultado <= c[0] on the same edge.
- MUL: acc <= (acc · x_reg) mod 2^WIDTH. If the full 2·WIDTH product >= 2^WIDTH, overflow <= 1. Next state: ADD.
- ADD:
  - acc <= (acc + c[idx-1]) mod 2^WIDTH; carry-out sets overflow <= 1.
  - idx <= idx-1.
  - If idx-1 == 0: resultado <= the same sum, next state FIN. Otherwise next state MUL.
- FIN: done = 1 for exactly this cycle. Next state IDLE unconditionally.
- Timing: if start is sampled at edge k, FIN is entered at edge k+2g, and done is high between edges k+2g and k+2g+1. A new start is accepted from edge k+2g+1 onward.
- start while busy=1 (including FIN) is ignored and not queued. Changes to x or grau after the start edge have no effect.
- overflow is sticky within one evaluation, cleared only at the next accepted start or at reset, and valid when done=1.
- resultado and overflow change only at the FIN-entry edge, at start (overflow only), and at reset.
- Coefficients above g are never read.

Test Plan:
- Reset with all inputs 0 → busy=0, done=0, resultado=0, overflow=0. Assert rst asynchronously mid-cycle → outputs clear before the next clk edge.
- DEGREE=3, write c3=9, c2=3, c1=2, c0=1; start with grau=2, x=5 → done high exactly 4 edges after the start edge, resultado=86, overflow=0, c3 unused.
- Write c3=2, c2=0, c1=4, c0=7; grau=3, x=5 → done 6 edges after start, resultado=277, overflow=0.
- c3=1, c2=c1=c0=0; grau=3, x=300 → resultado=64704 (27,000,000 mod 65536), overflow=1. A following run with grau=0 and c0=7 → resultado=7, overflow=0, done at the first cycle after the start edge.
- While busy: pulse coef_we to c0=100 and re-assert start with x=1 → c0 unchanged, no second evaluation, exactly one done pulse. grau=3 with coef_addr=3 write after completion → takes effect on the next run.
- Assert rst during MUL of a grau=3 run → no done pulse, resultado=0, busy=0, coefficients=0. A new start after reset completes normally with the expected values.

Source files
------------

// File: rtl/avaliador_polinomio_if.sv
// Bus between a host and the polynomial evaluator: coefficient load port,
// start/done handshake and the evaluation result.
interface avaliador_polinomio_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 2
);
    logic             coef_we;
    logic [AW-1:0]    coef_addr;
    logic [WIDTH-1:0] coef_data;
    logic [AW-1:0]    grau;
    logic [WIDTH-1:0] x;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] resultado;
    logic             overflow;

    modport master (
        output coef_we, coef_addr, coef_data, grau, x, start,
        input  busy, done, resultado, overflow
    );

    modport slave (
        input  coef_we, coef_addr, coef_data, grau, x, start,
        output busy, done, resultado, overflow
    );
endinterface

// File: rtl/avaliador_polinomio.sv
// Horner-method polynomial evaluator, unsigned and modulo 2^WIDTH, with a
// loadable coefficient bank, runtime degree, start/done handshake and overflow.
module avaliador_polinomio #(
    parameter int WIDTH  = 16,
    parameter int DEGREE = 3,
    parameter int AW     = 2
) (
    input logic                clk,
    input logic                rst,
    avaliador_polinomio_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, ADD, FIN} state_t;

    localparam logic [AW-1:0] DEG_MAX = AW'(DEGREE);

    state_t           state, state_next;
    logic [WIDTH-1:0] coef [DEGREE+1];
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] x_reg;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] res;
    logic             ovf;

    logic [AW-1:0]      g_sel;
    logic [AW-1:0]      idx_dec;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;

    // Degrees above the bank size are clamped rather than rejected.
    assign g_sel   = (bus.grau > DEG_MAX) ? DEG_MAX : bus.grau;
    assign idx_dec = idx - 1'b1;
    assign prod    = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, x_reg};
    assign sum     = {1'b0, acc} + {1'b0, coef[idx_dec]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first, so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE: if (bus.start) state_next = (g_sel != '0) ? MUL : FIN;
            MUL:  state_next = ADD;
            ADD:  state_next = (idx_dec == '0) ? FIN : MUL;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the bank is a small register file and must read as zero after reset.
            for (int i = 0; i <= DEGREE; i++) coef[i] <= '0;
            acc   <= '0;
            x_reg <= '0;
            idx   <= '0;
            res   <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.coef_we && bus.coef_addr <= DEG_MAX)
                        coef[bus.coef_addr] <= bus.coef_data;
                    if (bus.start) begin
                        x_reg <= bus.x;
                        acc   <= coef[g_sel];
                        idx   <= g_sel;
                        ovf   <= 1'b0;
                        if (g_sel == '0) res <= coef[0];
                    end
                end
                MUL: begin
                    acc <= prod[WIDTH-1:0];
                    if (prod[2*WIDTH-1:WIDTH] != '0) ovf <= 1'b1;
                end
                ADD: begin
                    acc <= sum[WIDTH-1:0];
                    idx <= idx_dec;
                    if (sum[WIDTH]) ovf <= 1'b1;
                    if (idx_dec == '0) res <= sum[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.resultado = res;
    assign bus.overflow  = ovf;
endmodule

// File: tb/tb_avaliador_polinomio.sv
// Directed bench for avaliador_polinomio (WIDTH=16, DEGREE=3) with
// hand-computed Horner results, latencies and overflow flags.
module tb_avaliador_polinomio;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    avaliador_polinomio_if #(.WIDTH(16), .AW(2)) bus ();

    avaliador_polinomio #(.WIDTH(16), .DEGREE(3), .AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_coef(input logic [1:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.coef_we   = 1'b1;
        bus.coef_addr = addr;
        bus.coef_data = data;
        @(negedge clk);
        bus.coef_we   = 1'b0;
    endtask

    task automatic load_bank(input logic [15:0] c3, c2, c1, c0);
        write_coef(2'd3, c3);
        write_coef(2'd2, c2);
        write_coef(2'd1, c1);
        write_coef(2'd0, c0);
    endtask

    // One evaluation: done must rise 2g edges after the start edge, exactly once.
    task automatic run_eval(input string name, input logic [1:0] g, input logic [15:0] xv,
                            input logic [15:0] exp_res, input logic exp_ovf, input bit disturb);
        int first;
        int ndone;
        int gi;
        gi = int'(g);
        @(negedge clk);
        bus.grau  = g;
        bus.x     = xv;
        bus.start = 1'b1;
        @(posedge clk);
        first = -1;
        ndone = 0;
        for (int n = 0; n < 2 * gi + 6; n++) begin
            @(negedge clk);
            if (n == 0) begin
                bus.start = 1'b0;
                bus.x     = 16'hFFFF;
                bus.grau  = 2'd0;
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy after start: got %b expected 1", name, bus.busy);
                end
                if (disturb) begin
                    bus.coef_we   = 1'b1;
                    bus.coef_addr = 2'd0;
                    bus.coef_data = 16'd100;
                    bus.start     = 1'b1;
                    bus.x         = 16'd1;
                end
            end
            if (n == 1 && disturb) begin
                bus.coef_we = 1'b0;
                bus.start   = 1'b0;
            end
            if (bus.done === 1'b1) begin
                ndone++;
                if (first < 0) first = n;
            end
        end
        checks++;
        if (first !== 2 * gi) begin
            errors++;
            $display("FAIL %s done latency: got %0d expected %0d", name, first, 2 * gi);
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL %s done pulses: got %0d expected 1", name, ndone);
        end
        checks++;
        if (bus.resultado !== exp_res) begin
            errors++;
            $display("FAIL %s resultado: got %0d expected %0d", name, bus.resultado, exp_res);
        end
        checks++;
        if (bus.overflow !== exp_ovf) begin
            errors++;
            $display("FAIL %s overflow: got %b expected %b", name, bus.overflow, exp_ovf);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy at end: got %b expected 0", name, bus.busy);
        end
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if ({bus.busy, bus.done, bus.overflow} !== 3'b000 || bus.resultado !== 16'd0) begin
            errors++;
            $display("FAIL %s outputs: got busy=%b done=%b ovf=%b res=%0d expected all 0",
                     name, bus.busy, bus.done, bus.overflow, bus.resultado);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        bus.grau = '0; bus.x = '0; bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        @(negedge clk);
        check_cleared("after_reset_release");
    endtask

    task automatic test_degree2();
        load_bank(16'd9, 16'd3, 16'd2, 16'd1);
        run_eval("deg2_x5", 2'd2, 16'd5, 16'd86, 1'b0, 1'b0);
    endtask

    task automatic test_degree3();
        load_bank(16'd2, 16'd0, 16'd4, 16'd7);
        run_eval("deg3_x5", 2'd3, 16'd5, 16'd277, 1'b0, 1'b0);
    endtask

    task automatic test_overflow_then_degree0();
        load_bank(16'd1, 16'd0, 16'd0, 16'd0);
        run_eval("deg3_x300_wrap", 2'd3, 16'd300, 16'd64704, 1'b1, 1'b0);
        write_coef(2'd0, 16'd7);
        run_eval("deg0_c0", 2'd0, 16'd123, 16'd7, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        // c = {1,0,0,7}: 5^3 + 7 = 132; writes and start while busy must be dropped.
        run_eval("busy_disturb", 2'd3, 16'd5, 16'd132, 1'b0, 1'b1);
        run_eval("c0_unchanged", 2'd0, 16'd0, 16'd7, 1'b0, 1'b0);
        write_coef(2'd3, 16'd2);
        run_eval("late_c3_write", 2'd3, 16'd5, 16'd257, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        int ndone;
        // Outputs are nonzero here; a mid-cycle reset clears them before any edge.
        load_bank(16'd1, 16'd0, 16'd0, 16'd0);
        run_eval("pre_reset_wrap", 2'd3, 16'd300, 16'd64704, 1'b1, 1'b0);
        @(negedge clk);
        bus.grau = 2'd3; bus.x = 16'd5; bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        rst = 1'b1;
        #1;
        check_cleared("async_reset_in_mul");
        ndone = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n == 2) rst = 1'b0;
            if (bus.done === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL aborted_run done pulses: got %0d expected 0", ndone);
        end
        check_cleared("after_abort");
        run_eval("coefs_cleared", 2'd3, 16'd5, 16'd0, 1'b0, 1'b0);
        load_bank(16'd9, 16'd3, 16'd2, 16'd1);
        run_eval("post_reset_deg2", 2'd2, 16'd5, 16'd86, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_degree2();
        test_degree3();
        test_overflow_then_degree0();
        test_busy_ignore();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
